// File: rtl/commit_unit_nport.sv
// commit_unit_nport
//   N-wide in-order commit stage between the scoreboard head and the
//   architectural state (register file, store buffer, CSR file, fence/flush).
//   Each cycle it retires the longest eligible in-order prefix of the head
//   entries. FENCE is serialised through a store-drain and flush handshake.
//   It also keeps a retired-instruction counter and reports port-0 exceptions.
//
// Ports
//   clk_i, rst_i              clock (rising edge), synchronous active-high reset
//   halt_i, single_step_i     halt blocks all retirement; single step allows port 0 only
//   instr_valid_i/ex_i        per-entry valid and exception flags (entry 0 oldest)
//   instr_kind_i (N x 2)      0=ALU/LOAD/MULT, 1=STORE, 2=CSR, 3=FENCE
//   instr_rd_i, instr_result_i  destination register and result / exception cause
//   commit_ack_o              per-entry retire strobe
//   we_o, waddr_o, wdata_o    register file write ports
//   commit_lsu_o, commit_lsu_ready_i, no_st_pending_i   store buffer handshake
//   commit_csr_o, csr_rdata_i CSR commit on port 0 and its read data
//   fence_o, flush_done_i     one-cycle flush request and completion
//   exception_valid_o/cause_o exception to the controller
//   busy_o                    fence sequence in progress
//   instret_o                 retired-instruction count (wraps)
module commit_unit_nport #(
  parameter int NR_COMMIT_PORTS = 4,
  parameter int XLEN            = 64,
  parameter int CNT_WIDTH       = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            halt_i,
  input  logic                            single_step_i,
  input  logic [NR_COMMIT_PORTS-1:0]      instr_valid_i,
  input  logic [NR_COMMIT_PORTS-1:0]      instr_ex_i,
  input  logic [NR_COMMIT_PORTS*2-1:0]    instr_kind_i,
  input  logic [NR_COMMIT_PORTS*5-1:0]    instr_rd_i,
  input  logic [NR_COMMIT_PORTS*XLEN-1:0] instr_result_i,
  output logic [NR_COMMIT_PORTS-1:0]      commit_ack_o,
  output logic [NR_COMMIT_PORTS-1:0]      we_o,
  output logic [NR_COMMIT_PORTS*5-1:0]    waddr_o,
  output logic [NR_COMMIT_PORTS*XLEN-1:0] wdata_o,
  output logic                            commit_lsu_o,
  input  logic                            commit_lsu_ready_i,
  input  logic                            no_st_pending_i,
  output logic                            commit_csr_o,
  input  logic [XLEN-1:0]                 csr_rdata_i,
  output logic                            fence_o,
  input  logic                            flush_done_i,
  output logic                            exception_valid_o,
  output logic [XLEN-1:0]                 exception_cause_o,
  output logic                            busy_o,
  output logic [CNT_WIDTH-1:0]            instret_o
);

  localparam int CW = $clog2(NR_COMMIT_PORTS + 1);

  typedef enum logic [1:0] {KIND_ALU = 2'd0, KIND_STORE = 2'd1,
                            KIND_CSR = 2'd2, KIND_FENCE = 2'd3} kind_t;
  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH_WAIT} state_t;

  state_t                     state_q, state_d;
  logic [NR_COMMIT_PORTS-1:0] prefix_ack;
  logic [NR_COMMIT_PORTS-1:0] ack;
  logic                       exc;
  logic                       fence;
  logic [CW-1:0]              ack_cnt;
  logic [CNT_WIDTH-1:0]       instret_q;
  kind_t                      kind0;

  assign kind0 = kind_t'(instr_kind_i[1:0]);

  // Longest in-order prefix that may retire together in IDLE. Younger ports
  // only take ALU/STORE work behind a non-serialising head, and at most one
  // store leaves per cycle.
  always_comb begin : prefix_logic
    logic  ok;
    logic  store_seen;
    kind_t kind_i;
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned; otherwise a latch is inferred.
    prefix_ack = '0;
    ok         = 1'b1;
    store_seen = 1'b0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      kind_i = kind_t'(instr_kind_i[2*i +: 2]);
      ok     = ok & instr_valid_i[i] & ~instr_ex_i[i];
      if (i > 0) begin
        ok = ok & (kind_i == KIND_ALU || kind_i == KIND_STORE)
                & (kind0 == KIND_ALU || kind0 == KIND_STORE)
                & ~single_step_i;
      end
      if (kind_i == KIND_STORE) begin
        ok = ok & commit_lsu_ready_i & ~store_seen;
      end
      prefix_ack[i] = ok;
      store_seen    = store_seen | (ok & (kind_i == KIND_STORE));
    end
  end

  // Next state and the retire/fence/exception decisions. Reset forces every
  // strobe low and aborts any fence sequence without raising fence_o.
  always_comb begin
    state_d = state_q;
    ack     = '0;
    fence   = 1'b0;
    exc     = 1'b0;
    if (rst_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!halt_i && instr_valid_i[0]) begin
            if (instr_ex_i[0])            exc     = 1'b1;
            else if (kind0 == KIND_FENCE) state_d = DRAIN;
            else                          ack     = prefix_ack;
          end
        end
        DRAIN: begin
          if (!instr_valid_i[0]) begin
            state_d = IDLE;
          end else if (no_st_pending_i && !halt_i) begin
            fence   = 1'b1;
            ack[0]  = 1'b1;
            state_d = FLUSH_WAIT;
          end
        end
        FLUSH_WAIT: begin
          if (flush_done_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Write-back and side-band strobes derived from the acks.
  always_comb begin
    we_o         = '0;
    wdata_o      = instr_result_i;
    commit_lsu_o = 1'b0;
    ack_cnt      = '0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      we_o[i] = ack[i]
              & (instr_kind_i[2*i +: 2] == KIND_ALU || instr_kind_i[2*i +: 2] == KIND_CSR)
              & (instr_rd_i[5*i +: 5] != 5'd0);
      commit_lsu_o = commit_lsu_o | (ack[i] & (instr_kind_i[2*i +: 2] == KIND_STORE));
      ack_cnt      = ack_cnt + CW'(ack[i]);
    end
    // A CSR on port 0 writes back the value read from the CSR file.
    if (kind0 == KIND_CSR) wdata_o[XLEN-1:0] = csr_rdata_i;
  end

  assign commit_ack_o      = ack;
  assign waddr_o           = instr_rd_i;
  assign commit_csr_o      = ack[0] & (kind0 == KIND_CSR);
  assign fence_o           = fence;
  assign exception_valid_o = exc;
  assign exception_cause_o = exc ? instr_result_i[XLEN-1:0] : '0;
  assign busy_o            = (state_q != IDLE);
  assign instret_o         = instret_q;

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q   <= IDLE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_q + CNT_WIDTH'(ack_cnt);
    end
  end

endmodule
